pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed 32-bit Fetch/Decode pipeline register.
- Generic inter-stage register with a valid/ready handshake, a 2-entry skid buffer, a hazard-unit stall and flush, and a configurable bubble value.
- Sits between any two pipeline stages (F/D, D/E, E/M, M/W), so the upstream stage never sees combinational backpressure.

Parameters:
- WIDTH, 32, payload width in bits (instruction plus sideband).
- BUBBLE_VAL, '0, value driven on out_data whenever no beat is held (the NOP encoding).
- CNT_W, 16, width of the perf counters; used only with PIPE_PERF_CNT_EN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- flush  in  1  hazard-unit flush; discards all held beats
- stall  in  1  hazard-unit stall; blocks consumption downstream
- in_valid  in  1  upstream beat valid
- in_ready  out  1  upstream may send; registered
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  downstream payload; BUBBLE_VAL when out_valid=0

Behaviour:
- Definitions: accept = in_valid & in_ready. consume = out_valid & out_ready & !stall.
- Storage: main register (drives out_data) and skid register.
- States, from a shared enum: PS_EMPTY, PS_ONE, PS_FULL.
- Outputs are purely state-decoded:
  - in_ready = (state != PS_FULL).
  - out_valid = (state != PS_EMPTY).
- Reset, when reset=0 at a clk edge:
  - state = PS_EMPTY.
  - main = skid = BUBBLE_VAL.
  - After reset: out_valid=0, in_ready=1, out_data=BUBBLE_VAL.
  - Reset mid-operation drops all held beats.
- Priority: reset > flush > normal operation.
- Flush, when flush=1 and reset=1:
  - Next state = PS_EMPTY; main and skid = BUBBLE_VAL.
  - A beat accepted in the same cycle is dropped, not stored.
  - stall is ignored in the flush cycle.
- PS_EMPTY:
  - accept: main <= in_data, go to PS_ONE.
  - otherwise: hold.
- PS_ONE:
  - accept & consume: main <= in_data, stay in PS_ONE.
  - accept & !consume: skid <= in_data, go to PS_FULL.
  - !accept & consume: main <= BUBBLE_VAL, go to PS_EMPTY.
  - neither: hold.
- PS_FULL:
  - consume: main <= skid, skid <= BUBBLE_VAL, go to PS_ONE.
  - no consume: hold. No accept is possible because in_ready=0.
- Latency and throughput:
  - 1 cycle from in_data to out_data.
  - Sustained throughput 1 beat/cycle with out_ready=1 and stall=0.
- Ordering: strict FIFO. No beat is lost or duplicated except by flush or reset.
- stall=1 is equivalent to out_ready=0 for state purposes. out_valid and out_data stay stable during a stall.
- out_data must never change while out_valid=1 and the beat has not been consumed.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, three output ports are added, all CNT_W wide, saturating at all-ones:
  - stall_cnt: cycles with stall=1 and out_valid=1.
  - flush_cnt: cycles with flush=1.
  - bubble_cnt: cycles with out_valid=0 and out_ready=1.
  - All three clear on reset.
  - flush does not clear them.
- When not defined:
  - The ports and counter logic are absent.
  - Handshake behaviour is identical in both builds.

Decomposition:
- Package pipe_pkg holds:
  - enum pipe_state_t {PS_EMPTY, PS_ONE, PS_FULL}.
  - Constants INSTR_W=32 and NOP_INSTR='0, used by stage instances.
- Sub-module sat_counter (parameter W; inputs clk, reset, inc; output cnt): a saturating counter instantiated three times, under PIPE_PERF_CNT_EN only.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, out_data=0, in_ready=1 throughout and 1 cycle after release.
- Streaming: out_ready=1, send 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles, each 1 cycle after input, in_ready stays 1.
- Skid fill: send 0xA then 0xB with out_ready=0 -> state PS_FULL, in_ready=0, out_data=0xA. Raise out_ready -> 0xA then 0xB delivered, in_ready=1 after the first consume.
- Stall: PS_ONE holding 0x55, stall=1 for 3 cycles with out_ready=1 -> out_valid=1, out_data=0x55 stable, no consume. Drop stall -> consumed next edge.
- Flush with full buffer: PS_FULL holding 0xA/0xB, flush=1 while in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=BUBBLE_VAL, in_ready=1; 0xC never appears.
- Perf counters (PIPE_PERF_CNT_EN, CNT_W=4): hold stall with out_valid=1 for 20 cycles -> stall_cnt saturates at 4'hF. Then flush -> flush_cnt=1 and stall_cnt unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for pipeline stage registers.
package pipe_pkg;

   // Default instruction width and the NOP encoding used as the bubble value.
   localparam int              INSTR_W   = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

   // Occupancy of a skid-buffered stage register.
   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_FULL  = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones,
// clears on synchronous active-low reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_ONE = W'(1);
   localparam logic [W-1:0] CNT_MAX = '1;

   // Count events until the counter reaches its maximum value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_ONE;
      end else begin
         cnt <= cnt;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid
// buffer, hazard stall/flush and a configurable bubble value.
// Optional macro PIPE_PERF_CNT_EN adds stall/flush/bubble perf counters.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int               WIDTH      = INSTR_W,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(NOP_INSTR),
   parameter int               CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             stall,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] bubble_cnt
`endif
);

   pipe_state_t      state;
   pipe_state_t      state_next;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] main_next;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_next;
   logic             accept;
   logic             consume;

   // Counter width must be usable when the perf counters are built.
   if (CNT_W < 1) begin : g_cnt_w_check
      $error("pipe_stage_skid: CNT_W must be at least 1");
   end

   assign accept   = in_valid & in_ready;
   assign consume  = out_valid & out_ready & ~stall;
   assign out_data = main_q;

   // Next-state and storage update; flush outranks all handshake activity.
   always_comb begin
      state_next = state;
      main_next  = main_q;
      skid_next  = skid_q;
      if (flush) begin
         state_next = PS_EMPTY;
         main_next  = BUBBLE_VAL;
         skid_next  = BUBBLE_VAL;
      end else begin
         case (state)
            PS_EMPTY: begin
               if (accept) begin
                  main_next  = in_data;
                  state_next = PS_ONE;
               end else begin
                  state_next = PS_EMPTY;
               end
            end
            PS_ONE: begin
               if (accept && consume) begin
                  main_next  = in_data;
                  state_next = PS_ONE;
               end else if (accept) begin
                  skid_next  = in_data;
                  state_next = PS_FULL;
               end else if (consume) begin
                  main_next  = BUBBLE_VAL;
                  state_next = PS_EMPTY;
               end else begin
                  state_next = PS_ONE;
               end
            end
            PS_FULL: begin
               // in_ready is low here, so only the drain path exists.
               if (consume) begin
                  main_next  = skid_q;
                  skid_next  = BUBBLE_VAL;
                  state_next = PS_ONE;
               end else begin
                  state_next = PS_FULL;
               end
            end
            default: begin
               // Unreachable encoding: recover to a clean empty stage.
               state_next = PS_EMPTY;
               main_next  = BUBBLE_VAL;
               skid_next  = BUBBLE_VAL;
            end
         endcase
      end
   end

   // State, storage and registered handshake outputs derived from next state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= PS_EMPTY;
         main_q    <= BUBBLE_VAL;
         skid_q    <= BUBBLE_VAL;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         main_q    <= main_next;
         skid_q    <= skid_next;
         in_ready  <= (state_next != PS_FULL);
         out_valid <= (state_next != PS_EMPTY);
      end
   end

`ifdef PIPE_PERF_CNT_EN
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall & out_valid),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush),
      .cnt   (flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (~out_valid & out_ready),
      .cnt   (bubble_cnt)
   );
`endif

endmodule
